// File: rtl/register_writeback_arbiter.sv
// Arbitrates the ALU and load writeback requesters onto the single register-file write port
// and tracks which destination registers still have an outstanding write.
module register_writeback_arbiter #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned ZERO_REG     = 31,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluAddress,
    input  logic [DATA_W-1:0] aluData,
    output logic              aluReady,
    input  logic              memValid,
    input  logic [ADDR_W-1:0] memAddress,
    input  logic [DATA_W-1:0] memData,
    output logic              memReady,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddress,
    input  logic [ADDR_W-1:0] readAddress1,
    input  logic [ADDR_W-1:0] readAddress2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeData
);

    localparam int unsigned       NumRegs   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroAddr  = ADDR_W'(ZERO_REG);
    localparam logic [3:0]        StarveMax = 4'(STARVE_LIMIT);

    logic [3:0]         r_starve;
    logic [3:0]         w_starve_next;
    logic [NumRegs-1:0] r_pending;
    logic [NumRegs-1:0] w_pending_next;
    logic               r_reg_write;
    logic [ADDR_W-1:0]  r_write_addr;
    logic [DATA_W-1:0]  r_write_data;

    logic               w_alu_win;
    logic               w_mem_win;
    logic               w_alu_hs;
    logic               w_mem_hs;
    logic               w_write_en;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]  w_win_data;

    // MEM has fixed priority unless the ALU has lost STARVE_LIMIT cycles in a row.
    always_comb begin
        w_alu_win  = aluValid && (!memValid || (r_starve == StarveMax));
        w_mem_win  = memValid && !w_alu_win;
        w_alu_hs   = w_alu_win && !reset;
        w_mem_hs   = w_mem_win && !reset;
        w_win_addr = w_alu_hs ? aluAddress : memAddress;
        w_win_data = w_alu_hs ? aluData : memData;
        w_write_en = (w_alu_hs || w_mem_hs) && (w_win_addr != ZeroAddr);
    end

    always_comb begin
        w_starve_next = r_starve;
        if (!aluValid || w_alu_hs) begin
            w_starve_next = 4'd0;
        end else if (w_mem_win && (r_starve != StarveMax)) begin
            w_starve_next = 4'(r_starve + 4'd1);
        end
    end

    // Clear first so a same-edge issue to the retiring address keeps the bit set.
    always_comb begin
        w_pending_next = r_pending;
        if (r_reg_write) begin
            w_pending_next[r_write_addr] = 1'b0;
        end
        if (issueValid && (issueAddress != ZeroAddr)) begin
            w_pending_next[issueAddress] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve     <= 4'd0;
            r_pending    <= '0;
            r_reg_write  <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            r_starve    <= w_starve_next;
            r_pending   <= w_pending_next;
            r_reg_write <= w_write_en;
            if (w_write_en) begin
                r_write_addr <= w_win_addr;
                r_write_data <= w_win_data;
            end
        end
    end

    assign aluReady     = w_alu_hs;
    assign memReady     = w_mem_hs;
    assign regWrite     = r_reg_write;
    assign writeAddress = r_write_addr;
    assign writeData    = r_write_data;
    assign hazard1      = r_pending[readAddress1] && (readAddress1 != ZeroAddr);
    assign hazard2      = r_pending[readAddress2] && (readAddress2 != ZeroAddr);

endmodule

// File: tb/tb_register_writeback_arbiter.sv
// Directed bench for register_writeback_arbiter: grant, starvation, scoreboard and reset checks.
module tb_register_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluAddress;
    logic [63:0] aluData;
    logic        aluReady;
    logic        memValid;
    logic [4:0]  memAddress;
    logic [63:0] memData;
    logic        memReady;
    logic        issueValid;
    logic [4:0]  issueAddress;
    logic [4:0]  readAddress1;
    logic [4:0]  readAddress2;
    logic        hazard1;
    logic        hazard2;
    logic        regWrite;
    logic [4:0]  writeAddress;
    logic [63:0] writeData;

    int n_checks = 0;
    int n_errors = 0;

    register_writeback_arbiter #(
        .ADDR_W      (5),
        .DATA_W      (64),
        .ZERO_REG    (31),
        .STARVE_LIMIT(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .aluValid    (aluValid),
        .aluAddress  (aluAddress),
        .aluData     (aluData),
        .aluReady    (aluReady),
        .memValid    (memValid),
        .memAddress  (memAddress),
        .memData     (memData),
        .memReady    (memReady),
        .issueValid  (issueValid),
        .issueAddress(issueAddress),
        .readAddress1(readAddress1),
        .readAddress2(readAddress2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .regWrite    (regWrite),
        .writeAddress(writeAddress),
        .writeData   (writeData)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starvation vectors: one row per cycle, both requesters streaming.
    logic       sv_mv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] sv_ma [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd0};
    logic [4:0] sv_aa [6] = '{5'd6, 5'd6, 5'd6, 5'd6, 5'd8, 5'd8};
    logic       sv_mr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       sv_ar [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0] sv_wa [6] = '{5'd1, 5'd2, 5'd3, 5'd6, 5'd4, 5'd8};

    initial begin
        reset        = 1'b1;
        aluValid     = 1'b0;
        aluAddress   = '0;
        aluData      = '0;
        memValid     = 1'b0;
        memAddress   = '0;
        memData      = '0;
        issueValid   = 1'b0;
        issueAddress = '0;
        readAddress1 = '0;
        readAddress2 = '0;
        #1;
        check_eq("rst_regwrite", regWrite, 0);
        check_eq("rst_waddr", writeAddress, 0);
        check_eq("rst_wdata", writeData, 0);
        check_eq("rst_hazard1", hazard1, 0);
        tick();
        tick();
        reset = 1'b0;

        // Single ALU write
        tick();
        aluValid = 1'b1; aluAddress = 5'd5; aluData = 64'h2A;
        #1;
        check_eq("alu_ready", aluReady, 1);
        check_eq("alu_memready", memReady, 0);
        tick();
        aluValid = 1'b0;
        check_eq("alu_wr", regWrite, 1);
        check_eq("alu_waddr", writeAddress, 5);
        check_eq("alu_wdata", writeData, 64'h2A);
        tick();
        check_eq("alu_wr_drop", regWrite, 0);
        check_eq("alu_waddr_hold", writeAddress, 5);

        // Starvation: MEM, MEM, MEM, ALU, MEM, ALU
        for (int k = 0; k < 6; k++) begin
            memValid   = sv_mv[k];
            memAddress = sv_ma[k];
            memData    = 64'h100 + 64'(sv_ma[k]);
            aluValid   = 1'b1;
            aluAddress = sv_aa[k];
            aluData    = 64'h200 + 64'(sv_aa[k]);
            #1;
            check_eq($sformatf("starve_memready_%0d", k), memReady, sv_mr[k]);
            check_eq($sformatf("starve_aluready_%0d", k), aluReady, sv_ar[k]);
            tick();
            check_eq($sformatf("starve_wr_%0d", k), regWrite, 1);
            check_eq($sformatf("starve_waddr_%0d", k), writeAddress, sv_wa[k]);
            check_eq($sformatf("starve_wdata_%0d", k), writeData,
                     (sv_ar[k] ? 64'h200 : 64'h100) + 64'(sv_wa[k]));
        end
        aluValid = 1'b0;
        memValid = 1'b0;
        tick();
        check_eq("starve_idle_wr", regWrite, 0);

        // Scoreboard hazard on register 7
        issueValid = 1'b1; issueAddress = 5'd7; readAddress1 = 5'd7; readAddress2 = 5'd31;
        #1;
        check_eq("hz_pre_issue", hazard1, 0);
        tick();
        issueValid = 1'b0;
        check_eq("hz_set", hazard1, 1);
        check_eq("hz_zero_rd2", hazard2, 0);
        aluValid = 1'b1; aluAddress = 5'd7; aluData = 64'h77;
        #1;
        check_eq("hz_hs_cycle", hazard1, 1);
        tick();
        aluValid = 1'b0;
        check_eq("hz_wr7", regWrite, 1);
        check_eq("hz_wr_cycle", hazard1, 1);
        tick();
        check_eq("hz_cleared", hazard1, 0);
        check_eq("hz_zero_rd2_end", hazard2, 0);

        // Write and issue to the zero register
        memValid = 1'b1; memAddress = 5'd31; memData = 64'hFFFF;
        issueValid = 1'b1; issueAddress = 5'd31; readAddress1 = 5'd31;
        #1;
        check_eq("zero_memready", memReady, 1);
        tick();
        memValid = 1'b0; issueValid = 1'b0;
        check_eq("zero_no_wr", regWrite, 0);
        check_eq("zero_wdata_hold", writeData, 64'h77);
        check_eq("zero_no_hazard", hazard1, 0);

        // Same-edge set and clear on register 9
        readAddress1 = 5'd9;
        issueValid = 1'b1; issueAddress = 5'd9;
        tick();
        issueValid = 1'b0;
        check_eq("ss_set", hazard1, 1);
        aluValid = 1'b1; aluAddress = 5'd9; aluData = 64'h99;
        tick();
        aluValid = 1'b0;
        issueValid = 1'b1; issueAddress = 5'd9;
        check_eq("ss_wr9", regWrite, 1);
        tick();
        issueValid = 1'b0;
        check_eq("ss_still_set", hazard1, 1);
        tick();
        check_eq("ss_still_set2", hazard1, 1);

        // Reset while a write is in flight and pending bits 3,4 are set
        issueValid = 1'b1; issueAddress = 5'd3;
        tick();
        issueAddress = 5'd4;
        tick();
        issueValid = 1'b0;
        readAddress1 = 5'd3; readAddress2 = 5'd4;
        aluValid = 1'b1; aluAddress = 5'd3; aluData = 64'h33;
        tick();
        aluAddress = 5'd4; aluData = 64'h44;
        #1;
        check_eq("prerst_wr", regWrite, 1);
        check_eq("prerst_hz1", hazard1, 1);
        check_eq("prerst_hz2", hazard2, 1);
        reset = 1'b1;
        #1;
        check_eq("mrst_wr", regWrite, 0);
        check_eq("mrst_waddr", writeAddress, 0);
        check_eq("mrst_hz1", hazard1, 0);
        check_eq("mrst_hz2", hazard2, 0);
        check_eq("mrst_aluready", aluReady, 0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("postrst_aluready", aluReady, 1);
        tick();
        aluValid = 1'b0;
        check_eq("postrst_wr", regWrite, 1);
        check_eq("postrst_waddr", writeAddress, 4);
        check_eq("postrst_wdata", writeData, 64'h44);
        check_eq("postrst_hz2", hazard2, 0);
        tick();
        check_eq("postrst_wr_drop", regWrite, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/register_writeback_arbiter.md
Name: register_writeback_arbiter

Overview:
Shares the single write port of the 32x64 register file between two writeback requesters, the ALU and the memory/load unit. It uses valid/ready handshakes, fixed MEM priority, and an anti-starvation counter for the ALU. It registers the winning write onto the register file's regWrite/writeAddress/writeData inputs. It also keeps a per-register pending scoreboard so decode can stall on read-after-write hazards against both read ports.

Parameters:
ADDR_W, 5, register address width
DATA_W, 64, register data width
ZERO_REG, 31, hardwired-zero register index; writes to it are discarded and issues to it are ignored
STARVE_LIMIT, 3, consecutive ALU-waiting cycles lost to MEM before the ALU is forced a grant (range 1..15)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
aluValid  input  1  ALU writeback request
aluAddress  input  ADDR_W  ALU destination register
aluData  input  DATA_W  ALU result
aluReady  output  1  ALU request accepted this cycle
memValid  input  1  load writeback request
memAddress  input  ADDR_W  load destination register
memData  input  DATA_W  load data
memReady  output  1  load request accepted this cycle
issueValid  input  1  decode issued an instruction that writes a register
issueAddress  input  ADDR_W  destination of the issued instruction
readAddress1  input  ADDR_W  decode source register 1
readAddress2  input  ADDR_W  decode source register 2
hazard1  output  1  readAddress1 has a pending write
hazard2  output  1  readAddress2 has a pending write
regWrite  output  1  write strobe to the register file
writeAddress  output  ADDR_W  write address to the register file
writeData  output  DATA_W  write data to the register file

Behaviour:
- Reset (asynchronous, any time including mid-handshake):
  - regWrite=0, writeAddress=0, writeData=0.
  - Pending bits all 0; starve counter 0.
  - aluReady=memReady=0 while reset is high; in-flight requests are dropped.
- Grant is combinational and evaluated each cycle:
  - memValid only -> MEM wins.
  - aluValid only -> ALU wins.
  - Both valid -> MEM wins unless starveCnt==STARVE_LIMIT, in which case ALU wins.
  - The loser's ready is 0 and it must hold valid, address and data stable.
- A handshake is valid&&ready; at most one handshake per cycle.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each cycle where aluValid=1 and MEM wins.
  - Clears to 0 on any ALU handshake, or on any cycle with aluValid=0.
- Output stage, 1-cycle latency:
  - On a handshake with address!=ZERO_REG, the next cycle has regWrite=1 and the winner's address and data.
  - Otherwise regWrite=0 next cycle; writeAddress and writeData hold their last values.
  - regWrite is never high for more than one cycle per handshake.
  - A handshake to ZERO_REG completes normally: ready=1, no write.
- Scoreboard, 32 bits:
  - An issue sets bit[issueAddress] at the clock edge when issueValid=1 and issueAddress!=ZERO_REG.
  - A bit clears at the edge ending a cycle in which regWrite=1 for that writeAddress.
  - Same-edge set and clear of the same address -> set wins (newer producer outstanding).
  - Issuing to an already-pending address keeps the bit set.
  - Only one producer per register may be outstanding; decode guarantees this.
- Hazard outputs:
  - hazardN = pending[readAddressN], combinational.
  - A readAddressN equal to ZERO_REG always gives 0.
  - The bit is therefore visible through the handshake cycle and the regWrite cycle, and drops the cycle after regWrite.
- Ordering:
  - Writes reach the register file in grant order.
  - Same-address writes from both requesters in one cycle: MEM (or the starvation-forced ALU) writes first and the other writes later, so the later grant is the final value.
  - Upstream owns program-order correctness.

Test Plan:
- Reset, then aluValid=1, aluAddress=5, aluData=0x2A -> aluReady=1 same cycle; next cycle regWrite=1, writeAddress=5, writeData=0x2A; following cycle regWrite=0.
- Both valid continuously, STARVE_LIMIT=3, MEM streaming addresses 1,2,3,4 -> grant sequence MEM, MEM, MEM, ALU, then MEM; starve counter returns to 0 after the ALU grant.
- issueValid with issueAddress=7, then readAddress1=7 -> hazard1=1 until the cycle after regWrite with writeAddress=7, then 0; readAddress2=31 -> hazard2=0 throughout.
- memValid with memAddress=31, memData=0xFFFF -> memReady=1; regWrite stays 0; issueAddress=31 sets no pending bit.
- Issue to address 9 in the same cycle regWrite=1 with writeAddress=9 -> bit 9 remains 1 after the edge and hazard stays asserted.
- Assert reset while aluValid=1 and pending bits {3,4} are set -> regWrite=0, hazards 0 and aluReady=0 immediately; after deassert the ALU request is granted fresh.
